// File: rtl/ps2_pkg.sv
// Shared types and defaults for the PS/2 keystroke queue.
// Holds the decoder state enum, prefix byte defaults and the key entry layout.
package ps2_pkg;

    localparam int         PS2_CODE_W     = 8;
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_t;

    typedef struct packed {
        logic                  ext;
        logic [PS2_CODE_W-1:0] code;
    } key_entry_t;

endpackage

// File: rtl/ps2_key_fifo.sv
// Generic first-word-fall-through FIFO with explicit occupancy counter.
// Ports: i_clk, i_rst (async, active-high), i_push/i_wdata write side,
//        i_pop read side, o_rdata head (zero when empty), o_empty, o_full,
//        o_count entries held 0..DEPTH.
module ps2_key_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_do_pop = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head forced to zero while empty so stale slots never leak out.
    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_count = r_count;

endmodule

// File: rtl/ps2_key_queue.sv
// PS/2 keystroke front end: decodes make/break/E0 prefixes and queues make codes.
// Ports: CLOCK_50, reset (async, active-high), rx_data/rx_en from the PS/2
//        receiver, key_ready consumer accept; key_valid/key_data/key_ext head,
//        key_count occupancy, overflow sticky drop flag.
// Build option KEY_REPEAT_FILTER_EN: suppress typematic repeats of a held key.
module ps2_key_queue
    import ps2_pkg::*;
#(
    parameter  int                DATA_W     = 8,
    parameter  int                DEPTH      = 8,
    parameter  logic [DATA_W-1:0] BREAK_CODE = DATA_W'(PS2_BREAK_CODE),
    parameter  logic [DATA_W-1:0] EXT_CODE   = DATA_W'(PS2_EXT_CODE),
    localparam int                CW         = $clog2(DEPTH + 1)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_en,
    input  logic              key_ready,
    output logic              key_valid,
    output logic [DATA_W-1:0] key_data,
    output logic              key_ext,
    output logic [CW-1:0]     key_count,
    output logic              overflow
);

    dec_state_t r_state;
    logic       r_overflow;

    logic            w_is_ext;
    logic            w_is_brk;
    logic            w_make;
    logic            w_brk;
    logic            w_ext;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic [DATA_W:0] w_entry;
    logic [DATA_W:0] w_head;

    assign w_is_ext = (rx_data == EXT_CODE);
    assign w_is_brk = (rx_data == BREAK_CODE);

    // w_make: byte completes a make code; w_brk: byte names a released key.
    always_comb begin
        w_make = 1'b0;
        w_brk  = 1'b0;
        w_ext  = 1'b0;
        if (rx_en) begin
            unique case (r_state)
                ST_IDLE: begin
                    w_make = !w_is_ext && !w_is_brk;
                end
                ST_EXT: begin
                    w_make = !w_is_ext && !w_is_brk;
                    w_ext  = 1'b1;
                end
                ST_BRK: begin
                    w_brk = 1'b1;
                end
                ST_EXT_BRK: begin
                    w_brk = 1'b1;
                    w_ext = 1'b1;
                end
                default: begin
                    w_make = 1'b0;
                end
            endcase
        end
    end

    assign w_entry = {w_ext, rx_data};

`ifdef KEY_REPEAT_FILTER_EN
    logic            r_held_vld;
    logic [DATA_W:0] r_held;
    logic            w_same;

    assign w_same = r_held_vld && (r_held == w_entry);
    assign w_push = w_make && !w_same;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_held_vld <= 1'b0;
            r_held     <= '0;
        end else if (w_push) begin
            r_held     <= w_entry;
            r_held_vld <= 1'b1;
        end else if (w_brk && w_same) begin
            r_held_vld <= 1'b0;
        end
    end
`else
    logic w_unused_brk;

    assign w_unused_brk = w_brk;
    assign w_push       = w_make;
`endif

    assign w_pop = !w_empty && key_ready;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_overflow <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (rx_en) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_is_ext) begin
                            r_state <= ST_EXT;
                        end else if (w_is_brk) begin
                            r_state <= ST_BRK;
                        end
                    end
                    ST_EXT: begin
                        if (w_is_brk) begin
                            r_state <= ST_EXT_BRK;
                        end else if (!w_is_ext) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    ps2_key_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLOCK_50),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_wdata (w_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (key_count)
    );

    assign key_valid = !w_empty;
    assign key_ext   = w_head[DATA_W];
    assign key_data  = w_head[DATA_W-1:0];
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_key_queue.sv
// Scoreboard bench for ps2_key_queue: byte-stream reference model feeds an
// expected queue; a negedge monitor compares head, count and overflow.
module tb_ps2_key_queue;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(DEPTH + 1);
`ifdef KEY_REPEAT_FILTER_EN
    localparam bit FILTER  = 1'b1;
    localparam int REP_EXP = 2;
`else
    localparam bit FILTER  = 1'b0;
    localparam int REP_EXP = 4;
`endif

    logic              CLOCK_50 = 1'b0;
    logic              reset    = 1'b1;
    logic [DATA_W-1:0] rx_data  = '0;
    logic              rx_en    = 1'b0;
    logic              key_ready = 1'b0;
    logic              key_valid;
    logic [DATA_W-1:0] key_data;
    logic              key_ext;
    logic [CW-1:0]     key_count;
    logic              overflow;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_key_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_en     (rx_en),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .key_data  (key_data),
        .key_ext   (key_ext),
        .key_count (key_count),
        .overflow  (overflow)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [8:0] exp_q [$];
    logic [8:0] cand_q [$];
    bit         m_ovf;
    bit         m_ext;
    bit         m_brk;
    bit         m_held_v;
    logic [8:0] m_held;

    task automatic chk(string name, int act, int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Byte-stream interpretation: pending prefix flags, makes become candidates.
    function automatic void model_byte(logic [7:0] b);
        logic [8:0] k;
        if (m_brk) begin
            k = {m_ext, b};
            if (FILTER && m_held_v && m_held == k) m_held_v = 1'b0;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            k = {m_ext, b};
            m_ext = 1'b0;
            if (!(FILTER && m_held_v && m_held == k)) begin
                cand_q.push_back(k);
                m_held   = k;
                m_held_v = 1'b1;
            end
        end
    endfunction

    task automatic cyc(bit en, logic [7:0] d, bit rdy);
        rx_en     = en;
        rx_data   = d;
        key_ready = rdy;
        if (en) model_byte(d);
        @(posedge CLOCK_50);
        #2;
        rx_en = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        rx_en     = 1'b0;
        key_ready = 1'b0;
        exp_q.delete();
        cand_q.delete();
        m_ovf    = 1'b0;
        m_ext    = 1'b0;
        m_brk    = 1'b0;
        m_held_v = 1'b0;
        #1;
        chk("rst_valid", key_valid, 0);
        chk("rst_data", key_data, 0);
        chk("rst_ext", key_ext, 0);
        chk("rst_count", key_count, 0);
        chk("rst_ovf", overflow, 0);
        @(posedge CLOCK_50);
        #2;
        reset = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 4 * DEPTH) begin
            cyc(1'b0, 8'h00, 1'b1);
            n++;
        end
        key_ready = 1'b0;
        chk("drain_bound", exp_q.size(), 0);
    endtask

    // Monitor: state check, then pop on handshake, then apply this cycle's push.
    always @(negedge CLOCK_50) begin : mon
        logic [8:0] c;
        if (!reset) begin
            chk("mon_count", key_count, exp_q.size());
            chk("mon_ovf", overflow, m_ovf);
            chk("mon_valid", key_valid, exp_q.size() != 0);
            if (exp_q.size() > 0) begin
                chk("mon_data", key_data, exp_q[0][7:0]);
                chk("mon_ext", key_ext, exp_q[0][8]);
                if (key_ready) void'(exp_q.pop_front());
            end
            while (cand_q.size() > 0) begin
                c = cand_q.pop_front();
                if (exp_q.size() < DEPTH) exp_q.push_back(c);
                else m_ovf = 1'b1;
            end
        end
    end

    logic [7:0] tbl [8];
    logic [7:0] rep_seq [6];

    initial begin
        tbl = '{8'hE0, 8'hF0, 8'h1C, 8'h75, 8'h2B, 8'h5A, 8'hE0, 8'hF0};
        rep_seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        @(posedge CLOCK_50);
        #2;
        do_reset();

        cyc(1'b1, 8'h1C, 1'b0);
        chk("make_valid", key_valid, 1);
        chk("make_data", key_data, 8'h1C);
        chk("make_ext", key_ext, 0);
        chk("make_count", key_count, 1);
        cyc(1'b1, 8'hF0, 1'b0);
        cyc(1'b1, 8'h1C, 1'b0);
        chk("brk_count", key_count, 1);
        cyc(1'b1, 8'hE0, 1'b0);
        cyc(1'b1, 8'h75, 1'b0);
        chk("ext_count", key_count, 2);
        cyc(1'b0, 8'h00, 1'b1);
        chk("ext_data", key_data, 8'h75);
        chk("ext_flag", key_ext, 1);
        drain();

        do_reset();
        for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
        chk("full_count", key_count, DEPTH);
        chk("full_ovf", overflow, 1);
        drain();
        chk("ovf_sticky", overflow, 1);

        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0);
        cyc(1'b1, 8'h30, 1'b1);
        chk("pp_count", key_count, DEPTH);
        chk("pp_ovf", overflow, 0);
        chk("pp_head", key_data, 8'h21);
        drain();

        cyc(1'b1, 8'h1C, 1'b0);
        cyc(1'b1, 8'h75, 1'b0);
        cyc(1'b1, 8'hE0, 1'b0);
        do_reset();
        cyc(1'b1, 8'h1C, 1'b0);
        chk("mid_data", key_data, 8'h1C);
        chk("mid_ext", key_ext, 0);
        chk("mid_count", key_count, 1);
        drain();

        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, rep_seq[i], 1'b0);
        chk("rep_count", key_count, REP_EXP);
        drain();

        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            int thr;
            thr = (ph == 0) ? 10 : (ph == 1) ? 60 : (ph == 2) ? 90 : 30;
            repeat (100) begin
                logic [7:0] b;
                b = ($urandom_range(0, 7) == 0) ? 8'($urandom) :
                    tbl[$urandom_range(0, 7)];
                cyc(1'($urandom_range(0, 1)), b,
                    $urandom_range(0, 99) < thr);
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
